// File: rtl/data_memory_arbiter.sv
// ============================================================================
// Module   : data_memory_arbiter
// Purpose  : Two-port (CPU / DMA) arbiter in front of a single-port data
//            memory, with DMA anti-starvation and bounded DMA bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuReqValid,
  output logic        cpuReqReady,
  input  logic [31:0] cpuAddress,
  input  logic [2:0]  cpuExtractExtend,
  input  logic [1:0]  cpuWriteType,
  input  logic [31:0] cpuWriteData,
  output logic        cpuRspValid,
  output logic [31:0] cpuRspData,
  input  logic        dmaReqValid,
  output logic        dmaReqReady,
  input  logic [31:0] dmaAddress,
  input  logic [2:0]  dmaExtractExtend,
  input  logic [1:0]  dmaWriteType,
  input  logic [31:0] dmaWriteData,
  input  logic        dmaReqLock,
  output logic        dmaRspValid,
  output logic [31:0] dmaRspData,
  output logic [31:0] dmAddress,
  output logic [2:0]  dmExtractExtend,
  output logic [1:0]  dmWriteType,
  output logic [31:0] dmWriteData,
  input  logic [31:0] dmReadData
);

  localparam logic [0:0] ST_ARB       = 1'b0;
  localparam logic [0:0] ST_DMA_BURST = 1'b1;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);

  logic [0:0] state;
  logic [0:0] state_next;
  logic [3:0] starve_count;
  logic [3:0] starve_next;
  logic [7:0] burst_count;
  logic [7:0] burst_next;
  logic       cpu_priority;
  logic       cpu_priority_next;
  logic       grant_cpu;
  logic       grant_dma;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_ARB;
      starve_count <= 4'd0;
      burst_count  <= 8'd0;
      cpu_priority <= 1'b0;
    end else begin
      state        <= state_next;
      starve_count <= starve_next;
      burst_count  <= burst_next;
      cpu_priority <= cpu_priority_next;
    end
  end

  always_comb begin
    state_next        = state;
    burst_next        = burst_count;
    cpu_priority_next = cpu_priority;

    if (!dmaReqValid || grant_dma) begin
      starve_next = 4'd0;
    end else if (starve_count < STARVE_MAX) begin
      starve_next = starve_count + 4'd1;
    end else begin
      starve_next = starve_count;
    end

    case (state)
      ST_ARB: begin
        // The CPU-priority slot after a capped burst lasts one ARB cycle only.
        cpu_priority_next = 1'b0;
        if (grant_dma && dmaReqLock) begin
          if (BURST_MAX == 8'd1) begin
            cpu_priority_next = 1'b1;
          end else begin
            state_next = ST_DMA_BURST;
            burst_next = 8'd1;
          end
        end
      end
      ST_DMA_BURST: begin
        if (!dmaReqValid || !dmaReqLock) begin
          state_next = ST_ARB;
          burst_next = 8'd0;
        end else if (burst_count + 8'd1 == BURST_MAX) begin
          state_next        = ST_ARB;
          burst_next        = 8'd0;
          cpu_priority_next = 1'b1;
        end else begin
          burst_next = burst_count + 8'd1;
        end
      end
      default: begin
        state_next = ST_ARB;
        burst_next = 8'd0;
      end
    endcase
  end

  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (!reset) begin
      case (state)
        ST_ARB: begin
          if (cpuReqValid &&
              (cpu_priority || !(dmaReqValid && starve_count == STARVE_MAX))) begin
            grant_cpu = 1'b1;
          end else if (dmaReqValid) begin
            grant_dma = 1'b1;
          end
        end
        ST_DMA_BURST: grant_dma = dmaReqValid;
        default: begin
          grant_cpu = 1'b0;
          grant_dma = 1'b0;
        end
      endcase
    end

    cpuReqReady = grant_cpu;
    dmaReqReady = grant_dma;

    if (grant_cpu) begin
      dmAddress       = cpuAddress;
      dmExtractExtend = cpuExtractExtend;
      dmWriteType     = cpuWriteType;
      dmWriteData     = cpuWriteData;
    end else if (grant_dma) begin
      dmAddress       = dmaAddress;
      dmExtractExtend = dmaExtractExtend;
      dmWriteType     = dmaWriteType;
      dmWriteData     = dmaWriteData;
    end else begin
      dmAddress       = 32'd0;
      dmExtractExtend = 3'd0;
      dmWriteType     = 2'd0;
      dmWriteData     = 32'd0;
    end
  end

  // Read data is captured at the same edge that commits any store of the grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpuRspValid <= 1'b0;
      cpuRspData  <= 32'd0;
      dmaRspValid <= 1'b0;
      dmaRspData  <= 32'd0;
    end else begin
      cpuRspValid <= grant_cpu;
      dmaRspValid <= grant_dma;
      if (grant_cpu) begin
        cpuRspData <= (cpuWriteType == 2'd0) ? dmReadData : 32'd0;
      end
      if (grant_dma) begin
        dmaRspData <= (dmaWriteType == 2'd0) ? dmReadData : 32'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
// ============================================================================
// Module   : tb_data_memory_arbiter
// Purpose  : Self-checking bench: directed scenarios plus random traffic
//            against a transaction-level arbitration and memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_BURST    = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpuReqValid, cpuReqReady, cpuRspValid;
  logic [31:0] cpuAddress, cpuWriteData, cpuRspData;
  logic [2:0]  cpuExtractExtend;
  logic [1:0]  cpuWriteType;
  logic        dmaReqValid, dmaReqReady, dmaReqLock, dmaRspValid;
  logic [31:0] dmaAddress, dmaWriteData, dmaRspData;
  logic [2:0]  dmaExtractExtend;
  logic [1:0]  dmaWriteType;
  logic [31:0] dmAddress, dmWriteData, dmReadData;
  logic [2:0]  dmExtractExtend;
  logic [1:0]  dmWriteType;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  logic        preload = 1'b0;

  // Reference model state
  bit m_bursting;
  int m_beats;
  int m_waited;
  bit m_cpu_first;
  int last_win;   // 0 none, 1 cpu, 2 dma

  always #5 clock = ~clock;

  data_memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset(reset),
    .cpuReqValid(cpuReqValid), .cpuReqReady(cpuReqReady), .cpuAddress(cpuAddress),
    .cpuExtractExtend(cpuExtractExtend), .cpuWriteType(cpuWriteType),
    .cpuWriteData(cpuWriteData), .cpuRspValid(cpuRspValid), .cpuRspData(cpuRspData),
    .dmaReqValid(dmaReqValid), .dmaReqReady(dmaReqReady), .dmaAddress(dmaAddress),
    .dmaExtractExtend(dmaExtractExtend), .dmaWriteType(dmaWriteType),
    .dmaWriteData(dmaWriteData), .dmaReqLock(dmaReqLock),
    .dmaRspValid(dmaRspValid), .dmaRspData(dmaRspData),
    .dmAddress(dmAddress), .dmExtractExtend(dmExtractExtend),
    .dmWriteType(dmWriteType), .dmWriteData(dmWriteData), .dmReadData(dmReadData)
  );

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] ee);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (32'(off) * 8));
    h = 16'(w >> (32'(off[1]) * 16));
    case (ee)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] off, input logic [1:0] wt);
    logic [31:0] mask;
    int          sh;
    case (wt)
      2'd1: begin sh = 32'(off) * 8;     mask = 32'hFF   << sh; end
      2'd2: begin sh = 32'(off[1]) * 16; mask = 32'hFFFF << sh; end
      default: begin sh = 0; mask = 32'hFFFF_FFFF; end
    endcase
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // Single-port memory: combinational read, write at the clock edge.
  assign dmReadData = extract(mem[dmAddress[9:2]], dmAddress[1:0], dmExtractExtend);

  always @(posedge clock) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= shadow[k];
    end else if (dmWriteType != 2'd0) begin
      mem[dmAddress[9:2]] <= merge(mem[dmAddress[9:2]], dmWriteData,
                                   dmAddress[1:0], dmWriteType);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick();
    if (m_bursting) return dmaReqValid ? 2 : 0;
    if (cpuReqValid && m_cpu_first) return 1;
    if (dmaReqValid && (!cpuReqValid || m_waited >= STARVE_LIMIT)) return 2;
    if (cpuReqValid) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_bursting = 0; m_beats = 0; m_waited = 0; m_cpu_first = 0; last_win = 0;
  endtask

  task automatic model_update(input int win);
    if (!m_bursting) m_cpu_first = 0;
    if (win == 2) begin
      m_waited = 0;
      if (dmaReqLock) begin
        m_beats    = m_bursting ? m_beats + 1 : 1;
        m_bursting = 1;
        if (m_beats >= MAX_BURST) begin
          m_bursting = 0; m_beats = 0; m_cpu_first = 1;
        end
      end else begin
        m_bursting = 0; m_beats = 0;
      end
    end else begin
      if (m_bursting && !dmaReqValid) begin
        m_bursting = 0; m_beats = 0;
      end
      if (dmaReqValid) m_waited = (m_waited < STARVE_LIMIT) ? m_waited + 1 : STARVE_LIMIT;
      else             m_waited = 0;
    end
  endtask

  // Called just after a rising edge with the requests already driven.
  task automatic cycle_check();
    int          win;
    logic [31:0] a, wd, exp_data;
    logic [2:0]  ee;
    logic [1:0]  wt;
    #4;
    win = model_pick();
    check("cpu_ready", 32'(cpuReqReady), 32'(win == 1));
    check("dma_ready", 32'(dmaReqReady), 32'(win == 2));
    a = 0; ee = 0; wt = 0; wd = 0;
    if (win == 1) begin a = cpuAddress; ee = cpuExtractExtend; wt = cpuWriteType; wd = cpuWriteData; end
    if (win == 2) begin a = dmaAddress; ee = dmaExtractExtend; wt = dmaWriteType; wd = dmaWriteData; end
    check("dm_addr", dmAddress, a);
    check("dm_ee",   32'(dmExtractExtend), 32'(ee));
    check("dm_wt",   32'(dmWriteType), 32'(wt));
    check("dm_wd",   dmWriteData, wd);
    exp_data = 0;
    if (win != 0) begin
      if (wt == 2'd0) exp_data = extract(shadow[a[9:2]], a[1:0], ee);
      else            shadow[a[9:2]] = merge(shadow[a[9:2]], wd, a[1:0], wt);
    end
    model_update(win);
    last_win = win;
    @(posedge clock);
    #1;
    check("cpu_rsp_valid", 32'(cpuRspValid), 32'(win == 1));
    check("dma_rsp_valid", 32'(dmaRspValid), 32'(win == 2));
    if (win == 1) check("cpu_rsp_data", cpuRspData, exp_data);
    if (win == 2) check("dma_rsp_data", dmaRspData, exp_data);
  endtask

  task automatic drain();
    dmaReqLock = 1'b0;
    if (last_win == 1) cpuReqValid = 1'b0;
    if (last_win == 2) dmaReqValid = 1'b0;
    for (int n = 0; n < 30 && (cpuReqValid || dmaReqValid); n++) begin
      cycle_check();
      if (last_win == 1) cpuReqValid = 1'b0;
      if (last_win == 2) dmaReqValid = 1'b0;
    end
    check("drain", 32'({cpuReqValid, dmaReqValid}), 32'd0);
  endtask

  task automatic gen_req(input int pct, output logic v, output logic [31:0] a,
                         output logic [2:0] ee, output logic [1:0] wt, output logic [31:0] wd);
    v  = ($urandom % 100) < pct;
    wt = ($urandom % 2) ? 2'($urandom_range(1, 3)) : 2'd0;
    ee = 3'($urandom_range(0, 4));
    a  = 32'($urandom_range(0, 127));
    if (wt == 2'd3 || (wt == 2'd0 && ee == 3'd0))     a[1:0] = 2'b00;
    else if (wt == 2'd2 || (wt == 2'd0 && ee >= 3'd3)) a[0]   = 1'b0;
    wd = $urandom;
  endtask

  task automatic set_cpu(input logic [31:0] a, input logic [2:0] ee, input logic [1:0] wt,
                         input logic [31:0] wd);
    cpuReqValid = 1'b1; cpuAddress = a; cpuExtractExtend = ee; cpuWriteType = wt; cpuWriteData = wd;
  endtask

  task automatic set_dma(input logic [31:0] a, input logic [2:0] ee, input logic [1:0] wt,
                         input logic [31:0] wd, input logic lock);
    dmaReqValid = 1'b1; dmaAddress = a; dmaExtractExtend = ee; dmaWriteType = wt;
    dmaWriteData = wd; dmaReqLock = lock;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wins [20];
    int f, cnt;
    cpuReqValid = 0; cpuAddress = 0; cpuExtractExtend = 0; cpuWriteType = 0; cpuWriteData = 0;
    dmaReqValid = 0; dmaAddress = 0; dmaExtractExtend = 0; dmaWriteType = 0; dmaWriteData = 0;
    dmaReqLock = 0;
    for (int k = 0; k < 256; k++) shadow[k] = $urandom;
    shadow[4] = 32'hDEAD_BEEF;
    model_reset();
    preload = 1'b1;
    repeat (3) @(posedge clock);
    preload = 1'b0;
    #1;
    check("rst_cpu_ready", 32'(cpuReqReady), 0);
    check("rst_dm_wt",     32'(dmWriteType), 0);
    check("rst_cpu_rsp",   32'(cpuRspValid), 0);
    check("rst_dma_rsp",   32'(dmaRspValid), 0);
    check("rst_cpu_data",  cpuRspData, 0);
    check("rst_dma_data",  dmaRspData, 0);
    reset = 1'b0;

    // CPU-only word load
    set_cpu(32'h10, 3'd0, 2'd0, 32'd0);
    cycle_check();
    check("t1_grant", 32'(last_win), 1);
    check("t1_data",  cpuRspData, 32'hDEAD_BEEF);
    cpuReqValid = 1'b0;

    // Idle cycles
    repeat (5) cycle_check();

    // Continuous contention: every fifth grant goes to DMA
    set_cpu(32'h0, 3'd0, 2'd0, 32'd0);
    set_dma(32'h8, 3'd0, 2'd0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle_check();
      check("t2_seq", 32'(last_win), (i % 5 == 4) ? 32'd2 : 32'd1);
    end
    drain();

    // Store then load on consecutive grants, with sign/zero extension
    set_dma(32'h21, 3'd0, 2'd1, 32'h7F, 1'b0);
    cycle_check();
    check("t3_sb_grant", 32'(last_win), 2);
    dmaReqValid = 1'b0;
    set_cpu(32'h21, 3'd2, 2'd0, 32'd0);
    cycle_check();
    check("t3_lbu", cpuRspData, 32'h0000_007F);
    cpuReqValid = 1'b0;
    set_dma(32'h22, 3'd0, 2'd1, 32'h80, 1'b0);
    cycle_check();
    dmaReqValid = 1'b0;
    set_cpu(32'h22, 3'd1, 2'd0, 32'd0);
    cycle_check();
    check("t3_lb", cpuRspData, 32'hFFFF_FF80);
    cpuReqValid = 1'b0;

    // Locked DMA burst capped at MAX_BURST with CPU pending throughout
    set_cpu(32'h10, 3'd0, 2'd0, 32'd0);
    set_dma(32'h30, 3'd0, 2'd0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle_check();
      wins[i] = last_win;
    end
    f = 19;
    for (int i = 19; i >= 0; i--) if (wins[i] == 2) f = i;
    check("t4_first_dma", 32'(f), STARVE_LIMIT);
    if (f > 11) f = 11;
    cnt = 0;
    for (int i = 0; i < MAX_BURST; i++) if (wins[f + i] == 2) cnt++;
    check("t4_burst_len", 32'(cnt), MAX_BURST);
    check("t4_cpu_slot",  32'(wins[f + MAX_BURST]), 1);
    drain();

    // Asynchronous reset mid-burst with a store presented
    set_dma(32'h80, 3'd0, 2'd0, 32'd0, 1'b1);
    repeat (3) cycle_check();
    set_dma(32'h40, 3'd0, 2'd3, 32'hCAFE_F00D, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("t5_dma_ready", 32'(dmaReqReady), 0);
    check("t5_dm_wt",     32'(dmWriteType), 0);
    check("t5_dma_rsp",   32'(dmaRspValid), 0);
    check("t5_dma_data",  dmaRspData, 0);
    check("t5_cpu_data",  cpuRspData, 0);
    @(posedge clock);
    #1;
    check("t5_no_write", mem[16], shadow[16]);
    reset = 1'b0;
    model_reset();
    dmaReqValid = 1'b0;
    dmaReqLock  = 1'b0;
    set_cpu(32'h10, 3'd0, 2'd0, 32'd0);
    cycle_check();
    check("t5_grant", 32'(last_win), 1);
    check("t5_data",  cpuRspData, 32'hDEAD_BEEF);
    cpuReqValid = 1'b0;

    // Random traffic; requesters hold their fields until granted
    for (int i = 0; i < 400; i++) begin
      if (!cpuReqValid || last_win == 1)
        gen_req(60, cpuReqValid, cpuAddress, cpuExtractExtend, cpuWriteType, cpuWriteData);
      if (!dmaReqValid || last_win == 2) begin
        gen_req(50, dmaReqValid, dmaAddress, dmaExtractExtend, dmaWriteType, dmaWriteData);
        dmaReqLock = ($urandom % 10) < 6;
      end
      cycle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
